// File: rtl/ph_fifo_array.sv
// Parasite-to-host FIFO array: NCH independent byte FIFOs written by the parasite
// and read by the host, with one optional two-byte channel and per-channel flush.
module ph_fifo_lane #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int LW     = 2,
  parameter bit IS_TWO = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  input  logic             one_byte_mode_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LW-1:0]    count_o,
  output logic             full_o,
  output logic             avail_o,
  output logic             ovf_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d, cap;
  logic             ovf_q, ovf_d;
  logic             pop, push, room;

  assign cap  = (IS_TWO && one_byte_mode_i) ? LW'(1) : LW'(DEPTH);
  assign room = count_q < cap;
  assign pop  = pop_req_i & (count_q != '0);
  // A same-cycle pop frees a slot, so a full (or over-cap) lane still accepts the push.
  assign push = push_req_i & (room | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req_i & ~room & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
  assign full_o  = count_q >= cap;
  assign avail_o = (IS_TWO && !one_byte_mode_i) ? (count_q >= LW'(2)) : (count_q != '0);
  assign ovf_o   = ovf_q;
endmodule

module ph_fifo_array #(
  parameter int NCH    = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 2,
  parameter int TWO_CH = 2,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic              h_phi2,
  input  logic              h_rst_b,
  input  logic              p_we,
  input  logic [NCH-1:0]    p_selectData,
  input  logic [WIDTH-1:0]  p_data,
  input  logic              h_rd,
  input  logic [NCH-1:0]    h_selectData,
  input  logic              one_byte_mode,
  input  logic [NCH-1:0]    flush,
  output logic [WIDTH-1:0]  h_data,
  output logic [NCH-1:0]    h_data_available,
  output logic              h_zero_bytes_available,
  output logic [NCH-1:0]    p_full,
  output logic [NCH*LW-1:0] h_level,
  output logic [NCH-1:0]    overflow
);
  logic [NCH-1:0]            grant;
  logic [NCH-1:0][WIDTH-1:0] rdata;
  logic [NCH-1:0][LW-1:0]    cnt;

  // Isolate the lowest set host select bit as a one-hot grant.
  assign grant = h_selectData & (~h_selectData + NCH'(1));

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    ph_fifo_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LW    (LW),
      .IS_TWO(gi == TWO_CH)
    ) u_lane (
      .clk_i          (h_phi2),
      .rst_n_i        (h_rst_b),
      .push_req_i     (p_we & p_selectData[gi]),
      .pop_req_i      (h_rd & grant[gi]),
      .one_byte_mode_i(one_byte_mode),
      .flush_i        (flush[gi]),
      .wdata_i        (p_data),
      .rdata_o        (rdata[gi]),
      .count_o        (cnt[gi]),
      .full_o         (p_full[gi]),
      .avail_o        (h_data_available[gi]),
      .ovf_o          (overflow[gi])
    );
    assign h_level[gi*LW +: LW] = cnt[gi];
  end

  always_comb begin
    h_data = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) h_data = h_data | rdata[i];
  end

  if (TWO_CH < NCH) begin : g_two
    assign h_zero_bytes_available = (cnt[TWO_CH] == '0);
  end else begin : g_no_two
    assign h_zero_bytes_available = 1'b1;
  end
endmodule
